// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// FIFO-to-serializer handshake plus the serial line and status outputs.
interface uart_tx_serializer_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] i_tx_data;
  logic                 i_tx_start;
  logic                 o_tx_start_clear;
  logic                 o_tx;
  logic                 o_busy;
  logic                 o_frame_done;

  // master = TX FIFO side, slave = serializer
  modport master (
    output i_tx_data, i_tx_start,
    input  o_tx_start_clear, o_tx, o_busy, o_frame_done
  );

  modport slave (
    input  i_tx_data, i_tx_start,
    output o_tx_start_clear, o_tx, o_busy, o_frame_done
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses o_tick on the last cycle of every CLKS_PER_BIT window.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign o_tick = i_en && (cnt_q == LAST);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!i_en || o_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART 8N1/8N2 transmit serializer, LSB first, with a FIFO start/clear handshake.
// Optional parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_serializer_if.slave  tx_if
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
    $error("uart_tx_serializer: illegal parameter set");
  end

  localparam logic [2:0] LAST_DATA_IDX = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP_IDX = 3'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic                 clear_q, clear_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tx_line;
  logic                 tick;
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
  logic parity_q, parity_d;
`endif

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .i_en   (state_q != ST_IDLE),
    .o_tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      clear_q <= clear_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    clear_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tx_line = IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_if.i_tx_start) begin
          state_d = ST_START;
          shift_d = tx_if.i_tx_data;
          idx_d   = '0;
          clear_d = 1'b1;
          busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d = (^tx_if.i_tx_data) ^ PAR_SENSE;
`endif
        end
      end
      ST_START: begin
        tx_line = ~IDLE_LEVEL;
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        tx_line = shift_q[0];
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_DATA_IDX) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_line = parity_q;
        if (tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // idx_q is reused here to count stop-bit periods
        if (tick) begin
          if (idx_q == LAST_STOP_IDX) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_if.o_tx             = tx_line;
  assign tx_if.o_tx_start_clear = clear_q;
  assign tx_if.o_busy           = busy_q;
  assign tx_if.o_frame_done     = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (1 and 2 stop bits, even/odd parity sense)
// checked cycle by cycle against a bit-period model of the frame.
module tb_uart_tx_serializer;

  localparam int N = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] start_v = '0;
  logic [7:0] data_v [2];
  logic [1:0] tx_w, busy_w, clr_w, done_w;
  int         cyc = 0;
  int         clr_cyc [2];
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_serializer_if bus0 ();
  uart_tx_serializer_if bus1 ();

  assign bus0.i_tx_data  = data_v[0];
  assign bus1.i_tx_data  = data_v[1];
  assign bus0.i_tx_start = start_v[0];
  assign bus1.i_tx_start = start_v[1];
  assign tx_w   = {bus1.o_tx, bus0.o_tx};
  assign busy_w = {bus1.o_busy, bus0.o_busy};
  assign clr_w  = {bus1.o_tx_start_clear, bus0.o_tx_start_clear};
  assign done_w = {bus1.o_frame_done, bus0.o_frame_done};

  uart_tx_serializer #(.CLKS_PER_BIT(N), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk (clk), .rst (rst), .tx_if (bus0)
  );
  uart_tx_serializer #(.CLKS_PER_BIT(N), .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
    .clk (clk), .rst (rst), .tx_if (bus1)
  );

  // Instance s has s+1 stop bits and parity sense s.
  function automatic int frame_len(input int s);
    return (9 + int'(PAR_EN) + s + 1) * N;
  endfunction

  // Expected line level at cycle i of the frame (cycle 0 = first start-bit cycle).
  function automatic logic exp_level(input int s, input logic [7:0] d, input int i);
    int b;
    b = i / N;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PAR_EN && b == 9) return (^d) ^ (s == 1);
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Entered and left on a negedge; leaves i_tx_start high when hold is set.
  task automatic send(input int s, input logic [7:0] d, input bit hold);
    int k;
    int len;
    k   = 0;
    len = frame_len(s);
    data_v[s]  = d;
    start_v[s] = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!clr_w[s] && k < 20);
    check("accept_latency", k, 1);
    clr_cyc[s] = cyc;
    data_v[s]  = ~d;
    for (int i = 0; i < len; i++) begin
      check("tx_line", tx_w[s], exp_level(s, d, i));
      check("busy", busy_w[s], 1);
      check("start_clear", clr_w[s], (i == 0));
      check("frame_done_early", done_w[s], 0);
      if (!hold) start_v[s] = 1'b0;
      @(negedge clk);
    end
    check("frame_done", done_w[s], 1);
    check("busy_after", busy_w[s], 0);
    check("tx_idle", tx_w[s], 1);
    check("clear_after", clr_w[s], 0);
  endtask

  initial begin
    int t0;
    logic [7:0] d;
    int s;
    bit hold;
    data_v[0] = '0;
    data_v[1] = '0;
    clr_cyc[0] = 0;
    clr_cyc[1] = 0;

    // Reset values, with a start request held during reset.
    repeat (2) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    check("rst_tx", tx_w, 2'b11);
    check("rst_busy", busy_w, 2'b00);
    check("rst_clear", clr_w, 2'b00);
    check("rst_done", done_w, 2'b00);
    start_v[0] = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_tx", tx_w, 2'b11);

    // Directed frames.
    send(0, 8'h55, 1'b0);
    repeat (2) @(negedge clk);
    send(1, 8'hA3, 1'b0);
    repeat (2) @(negedge clk);

    // Back-to-back with start held: one idle cycle, clear pulses frame_len+1 apart.
    send(0, 8'h01, 1'b1);
    t0 = clr_cyc[0];
    send(0, 8'h80, 1'b1);
    start_v[0] = 1'b0;
    check("clear_gap", clr_cyc[0] - t0, frame_len(0) + 1);
    @(negedge clk);
    check("no_retrigger", clr_w[0], 0);

    // Parity-sensitive byte on both instances.
    send(0, 8'h07, 1'b0);
    send(1, 8'h07, 1'b0);
    repeat (2) @(negedge clk);

    // Reset 15 cycles into a 0xFF frame, with start asserted alongside reset.
    data_v[0]  = 8'hFF;
    start_v[0] = 1'b1;
    @(negedge clk);
    check("pre_rst_clear", clr_w[0], 1);
    start_v[0] = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check("pre_rst_tx", tx_w[0], exp_level(0, 8'hFF, i));
      @(negedge clk);
    end
    rst = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", tx_w[0], 1);
    check("mid_rst_busy", busy_w[0], 0);
    check("mid_rst_clear", clr_w[0], 0);
    check("mid_rst_done", done_w[0], 0);
    rst = 1'b0;
    start_v[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_done", done_w[0], 0);
      check("post_rst_clear", clr_w[0], 0);
      check("post_rst_busy", busy_w[0], 0);
    end
    send(0, 8'($urandom), 1'b0);

    // Randomized frames on either instance.
    for (int n = 0; n < 8; n++) begin
      s    = int'($urandom_range(0, 1));
      d    = 8'($urandom);
      hold = 1'($urandom_range(0, 1));
      send(s, d, hold);
      start_v[s] = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
